conv_tile_sched: RTL
====================

Name: conv_tile_sched

Overview:
- Sequencer for one conv channel datapath: walks a TILES_X x TILES_Y grid of 4x4 image tiles and fetches each tile from the tile buffer.
- Drives the held tile and latched 3x3 kernel into the conv channel, then waits out the conv pipeline latency.
- 2x2 max-pools the four 20-bit conv results and emits one pooled value per tile over a valid/ready stream.
- Sits between the tile buffer / top control and the downstream feature-map writer.

Parameters:
- TILES_X, 3, tile positions per row (1..255)
- TILES_Y, 3, tile rows (1..255)
- CONV_LAT, 1, register stages inside the conv channel (1..7)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a grid pass when idle
- kernel_in  in  72  3x3 signed 8-bit kernel; latched on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last pooled output handshake
- tile_req  out  1  request for tile (tile_x, tile_y)
- tile_x  out  8  requested tile column index
- tile_y  out  8  requested tile row index
- tile_vld  in  1  tile_data valid; accepted when tile_req & tile_vld
- tile_data  in  128  16 unsigned 8-bit pixels, row-major, pixel[0][0] in bits 7:0
- conv_image  out  128  registered tile to conv channel
- conv_kernel  out  72  registered kernel to conv channel
- conv_res  in  80  signed 20-bit results {r11,r10,r01,r00}, r00 in bits 19:0
- pool_valid  out  1  pooled result valid
- pool_ready  in  1  downstream ready
- pool_data  out  20  signed pooled value
- pool_x  out  8  tile column of pool_data
- pool_y  out  8  tile row of pool_data

Behaviour:
- Reset values: busy, done, tile_req, and pool_valid are 0. tile_x, tile_y, pool_x, pool_y, pool_data, conv_image, and conv_kernel are 0. State is IDLE.
- FSM states: IDLE, FETCH, COMPUTE, OUT.
- IDLE -> FETCH on start: latch kernel_in into conv_kernel, set tx=ty=0, busy=1. start is ignored in every other state.
- FETCH: tile_req=1 with tile_x=tx, tile_y=ty. On tile_req & tile_vld: load conv_image from tile_data, clear cnt, go to COMPUTE. tile_vld without tile_req is ignored.
- COMPUTE: lasts CONV_LAT+1 cycles, with cnt incrementing each cycle.
  - conv_image and conv_kernel are held stable throughout.
  - On the edge where cnt==CONV_LAT: pool_data=signed max(r00,r01,r10,r11), pool_x=tx, pool_y=ty, pool_valid=1, go to OUT.
  - Result: pool_valid rises CONV_LAT+1 edges after the tile-accept edge.
- OUT: pool_valid, pool_data, pool_x, and pool_y are held stable while pool_ready=0. On pool_valid & pool_ready:
  - drop pool_valid;
  - if tx==TILES_X-1 and ty==TILES_Y-1, go to IDLE, pulse done next cycle, and clear busy;
  - otherwise, if tx==TILES_X-1, set tx=0 and ty=ty+1, then go to FETCH;
  - otherwise set tx=tx+1 and go to FETCH.
- Output order is row-major: (0,0),(1,0),...,(TILES_X-1,TILES_Y-1).
- done and busy low occur in the same cycle.
- Max comparison is signed 20-bit. Ties select any equal value (value-identical).
- rst asserted in any state, including mid-COMPUTE or OUT with pool_valid high, returns everything to reset values on the next edge. The partial pass is discarded.
- With TILES_X=TILES_Y=1, the pass is a single tile, then done.

Optional Feature:
- Macro: CONV_POOL_RELU_EN.
- Defined: pool_data = max(0, 4-way max), i.e. a negative result clamps to 20'sd0. Latency is unchanged.
- Undefined: pool_data is the raw signed 4-way max.

Decomposition:
- Package conv_pkg holds:
  - PIX_W=8, KW_W=8, CONV_W=20, TILE_BITS=128, KERN_BITS=72, IDX_W=8;
  - typedef sched_state_e {IDLE, FETCH, COMPUTE, OUT};
  - typedef conv_res_t as logic signed [CONV_W-1:0].
- One sub-module, pool_max4: combinational signed 4-input max with the optional ReLU clamp.

Test Plan:
- All-ones: kernel all 8'h01, tile all 8'h01, TILES_X=TILES_Y=1, CONV_LAT=1 -> pool_data=9 with pool_valid 2 edges after accept; done pulses once.
- Mixed ramp: kernel center 8'hFF, others 0; tile pixels 0..15 row-major -> r00=-5, r01=-6, r10=-9, r11=-10. Expect pool_data=-5, or 0 with CONV_POOL_RELU_EN.
- Grid order: TILES_X=3, TILES_Y=2, pool_ready always 1 -> six outputs in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); tile_req indices match; done after the sixth handshake.
- Backpressure: hold pool_ready=0 for 5 cycles in OUT -> pool_valid, pool_data, and indices stable; no new tile_req until the handshake.
- Fetch stall: tile_vld delayed 4 cycles -> tile_req held with stable indices; a second start pulse during busy is ignored, and exactly one pass completes.
- Mid-pass reset: rst during COMPUTE of tile (1,0) -> the next cycle shows all outputs 0 and IDLE; a fresh start restarts from (0,0).

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and widths for the conv tile scheduler and its pooling stage.
package conv_pkg;
  localparam int PIX_W     = 8;
  localparam int KW_W      = 8;
  localparam int CONV_W    = 20;
  localparam int TILE_BITS = 128;
  localparam int KERN_BITS = 72;
  localparam int IDX_W     = 8;

  typedef enum logic [1:0] {IDLE, FETCH, COMPUTE, OUT} sched_state_e;

  typedef logic signed [CONV_W-1:0] conv_res_t;
endpackage

// File: rtl/conv_tile_sched_pool_max4.sv
// Combinational signed 2x2 max-pool of four conv results.
// Build option CONV_POOL_RELU_EN clamps a negative pooled value to zero.
module pool_max4
  import conv_pkg::*;
(
  input  conv_res_t r00,
  input  conv_res_t r01,
  input  conv_res_t r10,
  input  conv_res_t r11,
  output conv_res_t pool_max
);
  function automatic conv_res_t smax(input conv_res_t a, input conv_res_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic conv_res_t relu(input conv_res_t v);
`ifdef CONV_POOL_RELU_EN
    return v[CONV_W-1] ? conv_res_t'(0) : v;
`else
    return v;
`endif
  endfunction

  assign pool_max = relu(smax(smax(r00, r01), smax(r10, r11)));
endmodule

// File: rtl/conv_tile_sched.sv
// Walks a TILES_X x TILES_Y tile grid, feeds each tile and the kernel to the conv
// channel, and streams one 2x2 max-pooled value per tile (CONV_POOL_RELU_EN optional).
module conv_tile_sched
  import conv_pkg::*;
#(
  parameter int TILES_X  = 3,
  parameter int TILES_Y  = 3,
  parameter int CONV_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KERN_BITS-1:0] kernel_in,
  output logic                 busy,
  output logic                 done,
  output logic                 tile_req,
  output logic [IDX_W-1:0]     tile_x,
  output logic [IDX_W-1:0]     tile_y,
  input  logic                 tile_vld,
  input  logic [TILE_BITS-1:0] tile_data,
  output logic [TILE_BITS-1:0] conv_image,
  output logic [KERN_BITS-1:0] conv_kernel,
  input  logic [4*CONV_W-1:0]  conv_res,
  output logic                 pool_valid,
  input  logic                 pool_ready,
  output conv_res_t            pool_data,
  output logic [IDX_W-1:0]     pool_x,
  output logic [IDX_W-1:0]     pool_y
);
  localparam logic [IDX_W-1:0] TX_LAST  = IDX_W'(TILES_X - 1);
  localparam logic [IDX_W-1:0] TY_LAST  = IDX_W'(TILES_Y - 1);
  localparam logic [2:0]       CNT_LAST = 3'(CONV_LAT);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] tx_q, ty_q;
  logic [2:0]       cnt_q;
  logic             launch, accept, res_take, hs, last_tile;
  conv_res_t        pool_max_p0;

  assign tile_req  = (state_q == FETCH);
  assign tile_x    = tx_q;
  assign tile_y    = ty_q;
  assign launch    = (state_q == IDLE) && start;
  assign accept    = tile_req && tile_vld;
  assign res_take  = (state_q == COMPUTE) && (cnt_q == CNT_LAST);
  assign hs        = (state_q == OUT) && pool_valid && pool_ready;
  assign last_tile = (tx_q == TX_LAST) && (ty_q == TY_LAST);

  pool_max4 u_pool (
    .r00      (conv_res[0*CONV_W +: CONV_W]),
    .r01      (conv_res[1*CONV_W +: CONV_W]),
    .r10      (conv_res[2*CONV_W +: CONV_W]),
    .r11      (conv_res[3*CONV_W +: CONV_W]),
    .pool_max (pool_max_p0)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = FETCH;
      FETCH:   if (accept)   state_d = COMPUTE;
      COMPUTE: if (res_take) state_d = OUT;
      OUT:     if (hs)       state_d = last_tile ? IDLE : FETCH;
      default:               state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_q       <= '0;
      ty_q       <= '0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pool_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= hs && last_tile;
      if (launch) begin
        tx_q <= '0;
        ty_q <= '0;
        busy <= 1'b1;
      end
      if (accept) cnt_q <= '0;
      else if (state_q == COMPUTE) cnt_q <= cnt_q + 3'd1;
      if (res_take) pool_valid <= 1'b1;
      else if (hs) pool_valid <= 1'b0;
      // Row-major advance; the final handshake ends the pass instead
      if (hs) begin
        if (last_tile) begin
          busy <= 1'b0;
        end else if (tx_q == TX_LAST) begin
          tx_q <= '0;
          ty_q <= ty_q + 1'b1;
        end else begin
          tx_q <= tx_q + 1'b1;
        end
      end
    end
  end

  // Stage boundary: held conv operands and the registered pooled result
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_image  <= '0;
      conv_kernel <= '0;
      pool_data   <= '0;
      pool_x      <= '0;
      pool_y      <= '0;
    end else begin
      if (launch) conv_kernel <= kernel_in;
      if (accept) conv_image  <= tile_data;
      if (res_take) begin
        pool_data <= pool_max_p0;
        pool_x    <= tx_q;
        pool_y    <= ty_q;
      end
    end
  end
endmodule
